// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - opcodes, funct codes, pipeline bus types and MUL FSM states for the execute stage
// Contents: OP_* opcodes, F_* ALU funct codes, id_ex_bus_t, ex_mem_bus_t,
//           EX_MEM_BUBBLE (NOP with all fields zero), mul_state_t.
package ex_stage_pkg;

  localparam logic [3:0] OP_NOP         = 4'h0;
  localparam logic [3:0] OP_ALUR        = 4'h1;
  localparam logic [3:0] OP_ALUI        = 4'h2;
  localparam logic [3:0] OP_LW          = 4'h3;
  localparam logic [3:0] OP_SW          = 4'h4;
  localparam logic [3:0] OP_MUL         = 4'h5;
  localparam logic [3:0] OP_DRAIN_CACHE = 4'h6;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_OR  = 4'h3;
  localparam logic [3:0] F_XOR = 4'h4;
  localparam logic [3:0] F_SLL = 4'h5;
  localparam logic [3:0] F_SRL = 4'h6;
  localparam logic [3:0] F_SRA = 4'h7;
  localparam logic [3:0] F_SLT = 4'h8;

  typedef struct packed {
    logic [31:0] instruction;
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] a_val;
    logic [31:0] b_val;
    logic [31:0] imm;
    logic [3:0]  funct;
  } id_ex_bus_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] b_val;
  } ex_mem_bus_t;

  localparam ex_mem_bus_t EX_MEM_BUBBLE = '{
    instruction: 32'h0,
    opcode:      OP_NOP,
    rd:          5'h0,
    alu_result:  32'h0,
    b_val:       32'h0
  };

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/iterative_multiplier.sv
// rtl/iterative_multiplier.sv - shift-and-add multiplier retiring MUL_BITS_PER_CYCLE bits of b per cycle
// Ports: clock, reset (sync, active-high); start/a_in/b_in launch a product from IDLE;
//        abort returns to IDLE from any state; accept releases DONE;
//        idle/busy/done reflect the FSM state; result is the 32-bit accumulator.
module iterative_multiplier
  import ex_stage_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        accept,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        idle,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int          K     = MUL_BITS_PER_CYCLE;
  localparam int          N     = 32 / K;
  localparam int          CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [31:0] K_U   = 32'(K);
  // For K == 32 the shift wraps to zero and the subtraction yields all ones.
  localparam logic [31:0] CHUNK_MASK = (K >= 32) ? 32'hFFFF_FFFF : ((32'd1 << K) - 32'd1);

  mul_state_t        state_q, state_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       shamt;
  logic [31:0]       chunk;
  logic [31:0]       partial;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    shamt   = 32'(cnt_q) * K_U;
    chunk   = (b_q >> shamt) & CHUNK_MASK;
    // Truncating before the shift is safe: bits pushed past 31 are lost either way.
    partial = a_q * chunk;
    if (abort) begin
      state_d = MUL_IDLE;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start) begin
            a_d     = a_in;
            b_d     = b_in;
            acc_d   = 32'h0;
            cnt_d   = '0;
            state_d = MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          acc_d = acc_q + (partial << shamt);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d = MUL_DONE;
          end
        end
        MUL_DONE: begin
          if (accept) begin
            state_d = MUL_IDLE;
          end
        end
        default: state_d = MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MUL_IDLE;
      acc_q   <= 32'h0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idle   = (state_q == MUL_IDLE);
  assign busy   = (state_q == MUL_BUSY);
  assign done   = (state_q == MUL_DONE);
  assign result = acc_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: inline ALU/address generation, iterative MUL, registered EX->MEM bus
// Ports: clock, reset (sync, active-high); id_ex_bus_in from ID; mem_stall_in holds the output;
//        flush_in kills the instruction in EX; ex_mem_bus_out registered to MEM;
//        ex_stall_out holds ID; mul_busy_out is high whenever the MUL FSM is not idle.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  id_ex_bus_t  id_ex_bus_in,
  input  logic        mem_stall_in,
  input  logic        flush_in,
  output ex_mem_bus_t ex_mem_bus_out,
  output logic        ex_stall_out,
  output logic        mul_busy_out
);

  ex_mem_bus_t ex_mem_q, ex_mem_d;
  ex_mem_bus_t computed;
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] alu_out;
  logic        is_mul;
  logic        mul_idle, mul_busy, mul_done;
  logic [31:0] mul_result;
  logic        mul_pending;

  assign is_mul      = (id_ex_bus_in.opcode == OP_MUL);
  assign mul_pending = mul_busy | (mul_idle & is_mul);
  assign ex_stall_out = ~reset & (mul_pending | mem_stall_in);
  assign mul_busy_out = ~mul_idle;

  // The FSM keeps iterating under a MEM stall; only the DONE->IDLE hand-off waits.
  iterative_multiplier #(
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clock  (clock),
    .reset  (reset),
    .start  (mul_idle & is_mul & ~flush_in),
    .abort  (flush_in),
    .accept (~mem_stall_in & ~flush_in),
    .a_in   (id_ex_bus_in.a_val),
    .b_in   (id_ex_bus_in.b_val),
    .idle   (mul_idle),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_result)
  );

  always_comb begin
    op2   = (id_ex_bus_in.opcode == OP_ALUI) ? id_ex_bus_in.imm : id_ex_bus_in.b_val;
    shamt = op2[4:0];
    case (id_ex_bus_in.funct)
      F_ADD:   alu_out = id_ex_bus_in.a_val + op2;
      F_SUB:   alu_out = id_ex_bus_in.a_val - op2;
      F_AND:   alu_out = id_ex_bus_in.a_val & op2;
      F_OR:    alu_out = id_ex_bus_in.a_val | op2;
      F_XOR:   alu_out = id_ex_bus_in.a_val ^ op2;
      F_SLL:   alu_out = id_ex_bus_in.a_val << shamt;
      F_SRL:   alu_out = id_ex_bus_in.a_val >> shamt;
      F_SRA:   alu_out = 32'($signed(id_ex_bus_in.a_val) >>> shamt);
      F_SLT:   alu_out = {31'h0, $signed(id_ex_bus_in.a_val) < $signed(op2)};
      default: alu_out = 32'h0;
    endcase

    computed.instruction = id_ex_bus_in.instruction;
    computed.opcode      = id_ex_bus_in.opcode;
    computed.rd          = id_ex_bus_in.rd;
    computed.b_val       = id_ex_bus_in.b_val;
    computed.alu_result  = 32'h0;
    case (id_ex_bus_in.opcode)
      OP_ALUR, OP_ALUI:              computed.alu_result = alu_out;
      OP_LW, OP_SW:                  computed.alu_result = id_ex_bus_in.a_val + id_ex_bus_in.imm;
      OP_NOP, OP_DRAIN_CACHE, OP_MUL: computed.alu_result = 32'h0;
      default:                       computed.opcode     = OP_NOP;
    endcase
  end

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (mem_stall_in) begin
      ex_mem_d = ex_mem_q;
    end else if (flush_in || mul_pending) begin
      ex_mem_d = EX_MEM_BUBBLE;
    end else if (mul_done) begin
      // ID has held the MUL instruction, so its instruction/rd/b_val are still on the input bus.
      ex_mem_d            = computed;
      ex_mem_d.alu_result = mul_result;
    end else begin
      ex_mem_d = computed;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_mem_q <= EX_MEM_BUBBLE;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ex_mem_bus_out = ex_mem_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly upstream of the MEM stage. Consumes the ID->EX pipeline bus and computes ALU results and load/store effective addresses.
- Runs MUL as an iterative multi-cycle operation.
- Drives a registered EX->MEM bus that holds while MEM stalls.
- Produces the stall back to IF/ID and accepts a flush from branch control.

Parameters:
- MUL_BITS_PER_CYCLE, 8, multiplier bits of operand b consumed per iteration; must divide 32. Iteration count N = 32/MUL_BITS_PER_CYCLE.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_ex_bus_in  in  id_ex_bus_t  instruction, opcode, rd, a_val, b_val, imm, funct.
- mem_stall_in  in  1  stall from MEM stage; EX output must hold.
- flush_in  in  1  kill the instruction currently in EX.
- ex_mem_bus_out  out  ex_mem_bus_t  registered: instruction, opcode, rd, alu_result, b_val.
- ex_stall_out  out  1  upstream must hold id_ex_bus_in.
- mul_busy_out  out  1  FSM not IDLE, for debug and perf counters.

Behaviour:
- Reset: clock and reset as above, reset synchronous and active-high. ex_mem_bus_out cleared to bubble (opcode NOP, all other fields 0). FSM to IDLE. Accumulator and counter to 0. ex_stall_out forced 0 while reset is high.
- Compute, combinational from id_ex_bus_in:
  - ALUopR: funct selects ADD, SUB, AND, OR, XOR, SLL, SRL, SRA or SLT on a_val and b_val.
  - ALUopI: same set on a_val and imm.
  - Shift amounts use bits [4:0]. SLT is signed and returns 1 or 0.
  - LW/SW: alu_result = a_val + imm (32-bit wrap); b_val is passed through.
  - DRAIN_CACHE and NOP: alu_result = 0, opcode passed through.
  - Unknown opcode: treated as NOP.
- FSM states: IDLE, MUL_BUSY, MUL_DONE.
- IDLE, opcode == MUL, no flush:
  - Latch a and b; acc = 0; cnt = 0; go to MUL_BUSY.
- MUL_BUSY, each cycle:
  - acc += (a * b[cnt*K +: K]) << (cnt*K), with K = MUL_BITS_PER_CYCLE, truncated to 32 bits.
  - cnt increments; after the N-th iteration go to MUL_DONE.
- MUL_DONE:
  - alu_result = acc (low 32 bits of the unsigned product, equal to the signed low product).
  - Go to IDLE on the cycle the output register accepts the result.
- mul_pending = (state == MUL_BUSY) or (state == IDLE and opcode == MUL).
- ex_stall_out = mul_pending or mem_stall_in.
- Output register update, per cycle, in priority order:
  1. mem_stall_in = 1: hold ex_mem_bus_out unchanged. FSM still iterates in MUL_BUSY but never leaves MUL_DONE.
  2. flush_in = 1: write bubble; FSM to IDLE, aborting any MUL.
  3. mul_pending = 1: write bubble.
  4. Otherwise: write the computed result, or acc in MUL_DONE.
- Latency:
  - Non-MUL ops: 1 cycle (registered).
  - MUL accepted at edge 0 appears on ex_mem_bus_out at edge N+2 with no MEM stall; ex_stall_out is high for N+1 cycles.
- Back-to-back MULs: the second is seen in IDLE on the cycle after the first is accepted; it introduces no extra bubble beyond its own N+1.
- flush_in together with mem_stall_in: flush still aborts the FSM; the held output remains; the flushed instruction never reaches MEM.
- Reset mid-MUL: immediate abort to IDLE, output bubble.

Decomposition:
- Shared package (Opcodes/PipelineInterface):
  - MUL and NOP opcodes.
  - ALU funct encodings.
  - id_ex_bus_t.
  - Bubble constant for ex_mem_bus_t.
  - mul_state_t enum.
- Sub-module iterative_multiplier (FSM, acc, cnt; start/a/b/abort in, busy/done/result out). The ALU stays inline combinational.

Test Plan:
- ALUopR ADD a=0x7FFFFFFF, b=1 -> next edge alu_result=0x80000000, rd passed through; SUB 5-7 -> 0xFFFFFFFE; SLT -1<1 -> 1.
- LW a=0x100, imm=0x3C, mem_stall_in high for 3 cycles after issue -> alu_result=0x13C, held unchanged all 3 cycles, then the next instruction appears.
- MUL a=0x12345678, b=0x9ABCDEF0, N=4 -> ex_stall_out high 5 cycles, bubbles emitted, then alu_result=0x242D2080; MUL -3*7 -> 0xFFFFFFEB.
- MUL with mem_stall_in asserted in MUL_DONE for 2 cycles -> state stays MUL_DONE, result emitted the cycle after stall drops, no duplicate.
- flush_in at iteration 2 of a MUL -> FSM returns to IDLE, output is a bubble, ex_stall_out drops next cycle, no MUL result is ever emitted.
- reset asserted during MUL_BUSY -> next edge: output NOP/zeros, mul_busy_out=0; a following ADD completes normally.
